// File: rtl/neural_layer_seq.sv
// Time-multiplexed perceptron layer: one shared MAC walks every neuron/input pair,
// with a streamed parameter load and valid/ready handshakes on input and output.
module neural_layer_seq #(
  parameter int N_IN     = 4,
  parameter int N_NEURON = 4,
  parameter int DW       = 8,
  parameter int ACCW     = 2*DW + $clog2(N_IN) + 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   act_mode,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [DW-1:0]          load_data,
  output logic                   params_ok,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*DW-1:0]     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_NEURON*DW-1:0] out_data,
  output logic                   busy
);

  localparam int NPAR = N_NEURON * (N_IN + 2);
  localparam int PW   = (NPAR > 1) ? $clog2(NPAR) : 1;
  localparam int KW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int NW   = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;

  localparam logic [PW-1:0] STRIDE  = PW'(N_IN + 2);
  localparam logic [PW-1:0] BIAS_OF = PW'(N_IN);
  localparam logic [PW-1:0] LAST_WC = PW'(NPAR - 1);
  localparam logic [KW-1:0] LAST_K  = KW'(N_IN - 1);
  localparam logic [NW-1:0] LAST_N  = NW'(N_NEURON - 1);
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-DW){1'b0}}, {DW{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          wc_q, wc_d;
  logic [NW-1:0]          n_q, n_d;
  logic [KW-1:0]          k_q, k_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   params_ok_q, params_ok_d;

  // Parameter words are kept in load order: per neuron N_IN weights, bias, threshold.
  logic [DW-1:0] par_q [NPAR];
  logic [DW-1:0] x_q   [N_IN];
  logic [DW-1:0] out_q [N_NEURON];

  logic                   par_we_s, cap_s, out_we_s, in_ready_s;
  logic [PW-1:0]          wi_s, bi_s, ti_s;
  logic signed [ACCW-1:0] xe_s, we_s, bias_s, th_s, prod_s, sum_s;
  logic [DW-1:0]          act_s;

  assign in_ready_s = (state_q == S_IDLE) && params_ok_q && !load_start;

  // MAC operand selection and the running sum for the current (n, k) pair.
  always_comb begin
    wi_s   = PW'(n_q) * STRIDE + PW'(k_q);
    bi_s   = PW'(n_q) * STRIDE + BIAS_OF;
    ti_s   = bi_s + PW'(1);
    xe_s   = {{(ACCW-DW){1'b0}}, x_q[k_q]};
    we_s   = {{(ACCW-DW){par_q[wi_s][DW-1]}}, par_q[wi_s]};
    bias_s = {{(ACCW-DW){par_q[bi_s][DW-1]}}, par_q[bi_s]};
    th_s   = {{(ACCW-DW){par_q[ti_s][DW-1]}}, par_q[ti_s]};
    prod_s = xe_s * we_s;
    if (k_q == {KW{1'b0}}) begin
      sum_s = bias_s + prod_s;
    end else begin
      sum_s = acc_q + prod_s;
    end
  end

  // Activation of the final sum: threshold gate, then step or clamped ReLU.
  always_comb begin
    act_s = {DW{1'b0}};
    if (sum_s < th_s) begin
      act_s = {DW{1'b0}};
    end else if (!act_mode) begin
      act_s = {DW{1'b1}};
    end else if (sum_s[ACCW-1]) begin
      act_s = {DW{1'b0}};
    end else if (sum_s > MAXV) begin
      act_s = {DW{1'b1}};
    end else begin
      act_s = sum_s[DW-1:0];
    end
  end

  // Next-state and datapath-enable logic.
  always_comb begin
    state_d     = state_q;
    wc_d        = wc_q;
    n_d         = n_q;
    k_d         = k_q;
    acc_d       = acc_q;
    params_ok_d = params_ok_q;
    par_we_s    = 1'b0;
    cap_s       = 1'b0;
    out_we_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d     = S_LOAD;
          wc_d        = {PW{1'b0}};
          params_ok_d = 1'b0;
        end else if (in_valid && in_ready_s) begin
          state_d = S_COMPUTE;
          cap_s   = 1'b1;
          n_d     = {NW{1'b0}};
          k_d     = {KW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          par_we_s = 1'b1;
          if (wc_q == LAST_WC) begin
            state_d     = S_IDLE;
            wc_d        = {PW{1'b0}};
            params_ok_d = 1'b1;
          end else begin
            wc_d = wc_q + PW'(1);
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_COMPUTE: begin
        acc_d = sum_s;
        if (k_q == LAST_K) begin
          out_we_s = 1'b1;
          k_d      = {KW{1'b0}};
          if (n_q == LAST_N) begin
            state_d = S_DONE;
            n_d     = {NW{1'b0}};
          end else begin
            n_d = n_q + NW'(1);
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wc_q        <= {PW{1'b0}};
      n_q         <= {NW{1'b0}};
      k_q         <= {KW{1'b0}};
      acc_q       <= {ACCW{1'b0}};
      params_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wc_q        <= wc_d;
      n_q         <= n_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      params_ok_q <= params_ok_d;
    end
  end

  // Parameter store, captured input vector and output lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPAR; i++) par_q[i] <= {DW{1'b0}};
      for (int i = 0; i < N_IN; i++) x_q[i] <= {DW{1'b0}};
      for (int i = 0; i < N_NEURON; i++) out_q[i] <= {DW{1'b0}};
    end else begin
      if (par_we_s) par_q[wc_q] <= load_data;
      if (cap_s) begin
        for (int i = 0; i < N_IN; i++) x_q[i] <= in_data[i*DW +: DW];
      end
      if (out_we_s) out_q[n_q] <= act_s;
    end
  end

  for (genvar j = 0; j < N_NEURON; j++) begin : g_lane
    assign out_data[j*DW +: DW] = out_q[j];
  end

  assign params_ok = params_ok_q;
  assign in_ready  = in_ready_s;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_LOAD) || (state_q == S_COMPUTE);

endmodule

// File: tb/tb_neural_layer_seq.sv
// Directed bench for neural_layer_seq with default parameters (4 inputs, 4 neurons, 8-bit).
module tb_neural_layer_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        act_mode = 1'b0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = 8'd0;
  logic        params_ok;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  int tests_run = 0;
  int failed = 0;
  logic [7:0] pw [24];

  neural_layer_seq dut (
    .clk(clk), .reset(reset), .act_mode(act_mode),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .params_ok(params_ok), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] w, input logic [7:0] b, input logic [7:0] th);
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) pw[j*6+k] = w;
      pw[j*6+4] = b;
      pw[j*6+5] = th;
    end
  endtask

  task automatic load_params();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      load_valid = 1'b1;
      load_data  = pw[i];
      tick();
    end
    load_valid = 1'b0;
    check("load_ok", params_ok, 1'b1);
  endtask

  // Accepts x, waits for out_valid within a bounded budget, leaves the block in DONE.
  task automatic run_infer(input logic [31:0] x, input logic mode, input logic [31:0] exp,
                           input string tag);
    int cyc;
    logic busy_ok;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    in_data  = x;
    in_valid = 1'b1;
    act_mode = mode;
    tick();
    in_valid = 1'b0;
    in_data  = ~x;
    cyc = 0;
    busy_ok = 1'b1;
    while (!out_valid && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd16);
    check({tag, "_busy"}, busy_ok, 1'b1);
    check({tag, "_data"}, out_data, exp);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drained"}, out_valid, 1'b0);
  endtask

  initial begin
    // Reset state, with in_valid asserted to show nothing is accepted.
    in_valid = 1'b1;
    in_data  = 32'h01020304;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_params_ok", params_ok, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    tick();
    check("rst_no_accept", busy, 1'b0);
    in_valid = 1'b0;

    // Sum path and parameter persistence.
    set_all(8'h01, 8'h00, 8'h00);
    load_params();
    run_infer({8'd40, 8'd30, 8'd20, 8'd10}, 1'b1, 32'h64646464, "sum");
    check("done_not_busy", busy, 1'b0);
    drain("sum");
    check("sum_retained", out_data, 32'h64646464);
    run_infer({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 32'hFFFFFFFF, "persist");
    drain("persist");

    // Saturation: s = 127 + 4*255*127 = 129667.
    set_all(8'h7F, 8'h7F, 8'h00);
    load_params();
    run_infer(32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, "sat_relu");
    drain("sat_relu");
    run_infer(32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, "sat_step");
    drain("sat_step");

    // Sign: lane0 sum is -1, other lanes sum to 0.
    set_all(8'h00, 8'h00, 8'h00);
    pw[0] = 8'hFF;
    load_params();
    run_infer(32'h00000001, 1'b0, 32'hFFFFFF00, "neg_step");
    drain("neg_step");
    for (int j = 0; j < 4; j++) pw[j*6+5] = 8'h80;
    load_params();
    run_infer(32'h00000001, 1'b0, 32'hFFFFFFFF, "th_step");

    // Backpressure in DONE with toggling input and a stray load_start.
    for (int i = 0; i < 5; i++) begin
      in_valid   = 1'b1;
      in_data    = $urandom;
      load_start = (i == 2);
      tick();
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_data", out_data, 32'hFFFFFFFF);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_busy", busy, 1'b0);
    end
    load_start = 1'b0;
    out_ready  = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_release_data", out_data, 32'hFFFFFFFF);
    in_valid = 1'b0;
    tick();
    check("bp_idle", busy, 1'b0);
    run_infer(32'h00000001, 1'b1, 32'h00000000, "th_relu");
    drain("th_relu");

    // Reset in the middle of compute.
    set_all(8'h01, 8'h00, 8'h00);
    load_params();
    in_data  = {8'd40, 8'd30, 8'd20, 8'd10};
    in_valid = 1'b1;
    act_mode = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_params_ok", params_ok, 1'b0);
    check("mrst_in_ready", in_ready, 1'b0);
    check("mrst_busy", busy, 1'b0);
    in_valid = 1'b0;
    load_params();
    run_infer({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 32'h0A0A0A0A, "after_reset");
    drain("after_reset");

    // load_start and in_valid together, then a stalled load with distinct parameters.
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) pw[j*6+k] = 8'(j + 1);
      pw[j*6+4] = 8'(j);
      pw[j*6+5] = 8'h00;
    end
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = {8'd4, 8'd3, 8'd2, 8'd1};
    #1;
    check("cont_in_ready", in_ready, 1'b0);
    tick();
    load_start = 1'b0;
    check("cont_params_ok", params_ok, 1'b0);
    check("cont_busy", busy, 1'b1);
    check("cont_load_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 24; i++) begin
      if (i % 7 == 3) begin
        load_valid = 1'b0;
        repeat (3) tick();
      end
      load_start = (i == 10);
      load_valid = 1'b1;
      load_data  = pw[i];
      tick();
      if (i == 22) begin
        check("partial_ok", params_ok, 1'b0);
        check("partial_busy", busy, 1'b1);
      end
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    in_valid   = 1'b0;
    check("stall_load_ok", params_ok, 1'b1);
    check("stall_load_busy", busy, 1'b0);
    run_infer({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, 32'h2B20150A, "order");
    drain("order");

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/neural_layer_seq.md
Name: neural_layer_seq

Overview:
- Parametrised, time-multiplexed perceptron layer: N_IN unsigned inputs, N_NEURON neurons, signed weights, bias and threshold per neuron.
- A single shared multiplier-accumulator computes one product per cycle.
- Parameters load as a word stream through a dedicated load handshake.
- Inference uses valid/ready handshakes on input and output, so layers can be chained or fed from the top-level shift-register path.

Parameters:
- N_IN, 4, inputs per neuron (≥1).
- N_NEURON, 4, neuron count (≥1).
- DW, 8, data/parameter word width.
- ACCW, 2*DW+$clog2(N_IN)+2, signed accumulator width. Must not be set smaller; no overflow occurs by construction.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- act_mode  input  1  activation select: 0 = step, 1 = thresholded saturating ReLU. Sampled once per neuron, on that neuron's final MAC cycle.
- load_start  input  1  pulse: begin parameter load. Honoured in IDLE only.
- load_valid  input  1  load_data is a valid parameter word.
- load_data  input  DW  parameter word, two's complement.
- params_ok  output  1  a complete parameter set is resident.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  N_IN*DW  input i at [i*DW +: DW], unsigned.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  N_NEURON*DW  neuron j at [j*DW +: DW], unsigned.
- busy  output  1  state is LOAD or COMPUTE.

Behaviour:
- Reset
  - Clears state to IDLE and clears all parameter registers, accumulator, counters and outputs.
  - Output reset values: params_ok=0, in_ready=0, out_valid=0, out_data=0, busy=0.
  - Reset mid-load or mid-compute discards everything; a full reload is required afterwards.
- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE
  - load_start=1 → LOAD. Word counter is cleared and params_ok is cleared the same edge.
  - Otherwise, in_valid && in_ready → COMPUTE, and in_data is captured into an internal register.
  - in_ready = (state==IDLE) && params_ok && !load_start. load_start wins over a simultaneous in_valid.
- LOAD
  - Each cycle with load_valid=1 stores load_data at index wc, then wc increments.
  - Word order per neuron j: w[j][0..N_IN-1], bias[j], th[j]. Neurons are loaded in ascending j.
  - Total word count is N_NEURON*(N_IN+2).
  - The cycle storing the last word → IDLE, and params_ok=1 from the next cycle.
  - load_valid=0 stalls without a timeout. load_start during LOAD is ignored.
- COMPUTE
  - Counters are neuron n (0..N_NEURON-1) and input k (0..N_IN-1); one MAC per cycle.
  - k==0: acc = sext(bias[n]) + x[0]*w[n][0].
  - k>0: acc = acc + x[k]*w[n][k].
  - Every product is unsigned input × signed weight, formed with a zero-extended input and a sign-extended weight.
  - On k==N_IN-1 the final sum s is evaluated in the same cycle and written to out_data lane n:
    - s < sext(th[n]) → 0.
    - Otherwise, act_mode=0 → 2^DW-1.
    - Otherwise, act_mode=1 → clamp(s, 0, 2^DW-1).
  - Then k=0 and n increments; after the last neuron → DONE.
  - Latency: with acceptance at edge E, out_valid is 1 after edge E+N_NEURON*N_IN (16 cycles with defaults).
  - out_data lanes are updated progressively during COMPUTE. This is not visible externally because out_valid=0 throughout.
- DONE
  - out_valid=1. out_data is held stable while out_ready=0.
  - out_valid && out_ready → IDLE, and out_valid=0 next cycle. out_data retains its value.
  - in_ready=0 and load_start is ignored in DONE.
- Held inputs and signals ignored outside their states
  - in_data changes after acceptance have no effect.
  - load_valid outside LOAD is ignored.
  - Parameters persist across any number of inferences.

Test Plan:
- Sum path: all w=1, bias=0, th=0, act_mode=1; in=10,20,30,40 → all lanes 100, out_valid exactly 16 cycles after acceptance, busy high for those cycles.
- Saturation: all w=0x7F, bias=0x7F, th=0; in=255×4 → s=129667. Lanes 255 in both modes, no wrap.
- Sign and threshold:
  - w[0][0]=0xFF (−1), other weights 0, bias=0, th=0; in=1,0,0,0 → lane0=0.
  - Set th=0x80 (−128) → mode 0 lane0=255, mode 1 lane0=0 (negative clamp).
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and toggling in_data → out_valid/out_data stable, in_ready=0. Then raise out_ready → out_valid drops next cycle and in_ready returns.
- Reset mid-compute: assert reset at compute cycle 7 → next cycle out_valid=0, params_ok=0, in_ready=0, busy=0. Reload then infer gives correct results.
- Contention and partial load:
  - load_start and in_valid in the same IDLE cycle → LOAD entered, input not accepted, params_ok=0.
  - Stalled partial load (load_valid gaps) still completes at word 24 with defaults.
